// File: rtl/ppg_window_ctrl.sv
// Ping-pong window sequencer for a true dual-port sample RAM.
// Port A writes incoming samples into one half while port B reads the other
// completed half back out over a valid/ready stream, one window at a time.
module ppg_window_ctrl #(
    parameter int DATA_W = 22,
    parameter int ADDR_W = 11,
    parameter int WIN    = 750,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [DATA_W-1:0] ram_data_a,
    output logic              ram_we_a,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic [DATA_W-1:0] ram_data_b,
    output logic              ram_we_b,
    input  logic [DATA_W-1:0] ram_q_b,
    output logic              overrun,
    output logic [CNT_W-1:0]  win_count
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_OUT} rd_state_t;

    localparam logic [ADDR_W-1:0] WIN_A    = ADDR_W'(WIN);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WIN - 1);

    rd_state_t         state, state_nxt;
    logic              wr_half;
    logic [ADDR_W-1:0] wr_idx;
    logic              rd_half;
    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W-1:0] addr_b_q;
    logic [ADDR_W-1:0] rd_addr;
    logic              handshake;
    logic              win_done;
    logic              rd_free;
    logic              handover;

    // A window may be handed over when the reader is idle or is just
    // accepting its final sample, so back-to-back windows lose no cycle.
    assign handshake = (state == R_OUT) && m_valid && m_ready;
    assign win_done  = s_valid && (wr_idx == LAST_IDX);
    assign rd_free   = (state == R_IDLE) || (handshake && m_last);
    assign handover  = win_done && rd_free;
    assign rd_addr   = (rd_half ? WIN_A : '0) + rd_idx;

    assign ram_we_a   = s_valid;
    assign ram_addr_a = (wr_half ? WIN_A : '0) + wr_idx;
    assign ram_data_a = s_data;
    assign ram_data_b = '0;
    assign ram_we_b   = 1'b0;
    assign ram_addr_b = (state == R_ADDR) ? rd_addr : addr_b_q;

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= R_IDLE;
        else     state <= state_nxt;
    end

    // Read FSM next state: address, wait for registered RAM data, present.
    always_comb begin
        state_nxt = state;
        case (state)
            R_IDLE: if (handover) state_nxt = R_ADDR;
            R_ADDR: state_nxt = R_DATA;
            R_DATA: state_nxt = R_OUT;
            R_OUT: begin
                if (handshake) begin
                    if (m_last) state_nxt = handover ? R_ADDR : R_IDLE;
                    else        state_nxt = R_ADDR;
                end
            end
            default: state_nxt = R_IDLE;
        endcase
    end

    // Write side: every sample is stored; a full window is either handed to
    // the reader (toggle halves) or dropped by rewriting the same half.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_half   <= 1'b0;
            wr_idx    <= '0;
            overrun   <= 1'b0;
            win_count <= '0;
        end else if (s_valid) begin
            if (win_done) begin
                wr_idx <= '0;
                if (handover) begin
                    wr_half   <= ~wr_half;
                    win_count <= win_count + CNT_W'(1);
                end else begin
                    overrun <= 1'b1;
                end
            end else begin
                wr_idx <= wr_idx + ADDR_W'(1);
            end
        end
    end

    // Read datapath: latch the address, capture RAM data into the output
    // register, and advance through the window on each accepted sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_half  <= 1'b0;
            rd_idx   <= '0;
            addr_b_q <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            m_data   <= '0;
        end else begin
            if (state == R_ADDR) addr_b_q <= rd_addr;
            if (state == R_DATA) begin
                m_data  <= ram_q_b;
                m_valid <= 1'b1;
                m_last  <= (rd_idx == LAST_IDX);
            end
            if (handshake) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
                if (!m_last) rd_idx <= rd_idx + ADDR_W'(1);
            end
            if (handover) begin
                rd_half <= wr_half;
                rd_idx  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ppg_window_ctrl.sv
// Bench for ppg_window_ctrl: behavioural dual-port RAM, a window writer that
// queues expected read-back samples, and an output monitor that scores them.
module tb_ppg_window_ctrl;

    localparam int DATA_W = 22;
    localparam int ADDR_W = 11;
    localparam int WIN    = 750;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic [ADDR_W-1:0] ram_addr_a;
    logic [DATA_W-1:0] ram_data_a;
    logic              ram_we_a;
    logic [ADDR_W-1:0] ram_addr_b;
    logic [DATA_W-1:0] ram_data_b;
    logic              ram_we_b;
    logic [DATA_W-1:0] ram_q_b;
    logic              overrun;
    logic [CNT_W-1:0]  win_count;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   rmode = 0;

    logic [DATA_W-1:0] mem [0:1502];

    ppg_window_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WIN(WIN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .ram_addr_a(ram_addr_a), .ram_data_a(ram_data_a), .ram_we_a(ram_we_a),
        .ram_addr_b(ram_addr_b), .ram_data_b(ram_data_b), .ram_we_b(ram_we_b),
        .ram_q_b(ram_q_b),
        .overrun(overrun), .win_count(win_count)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Sample RAM: write on port A, registered read on port B.
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
        ram_q_b <= mem[ram_addr_b];
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Downstream ready: 0 always, 1 never, 2 random, 3 stall on a last sample.
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rmode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'b0;
                2:       m_ready = ($urandom_range(0, 1) != 0);
                default: m_ready = !(m_valid && m_last);
            endcase
        end
    end

    // Monitor: score each accepted sample, and check stalled outputs hold.
    initial begin
        exp_t        e;
        logic              prev_stall;
        logic [DATA_W-1:0] prev_data;
        logic              prev_last;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check_output("stall_valid", m_valid, 1);
                    check_output("stall_data", m_data, prev_data);
                    check_output("stall_last", m_last, prev_last);
                end
                if (m_valid && m_ready) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_output: got data %0d, expected no output", m_data);
                    end else begin
                        e = sb.pop_front();
                        check_output("rd_data", m_data, e.data);
                        check_output("rd_last", m_last, e.last);
                        check_output("rd_addr", ram_addr_b, e.addr);
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
            end
        end
    end

    // Write n samples one per gap cycles; optionally queue them for read-back.
    task automatic apply_stimulus(input int first_val, input int n, input int gap,
                                  input int addr_base, input bit expect_read,
                                  input bit release_last);
        exp_t e;
        if (expect_read) begin
            for (int i = 0; i < n; i++) begin
                e.data = DATA_W'(first_val + i);
                e.last = (i == WIN - 1);
                e.addr = ADDR_W'(addr_base + i);
                sb.push_back(e);
            end
        end
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            s_valid = 1'b1;
            s_data  = DATA_W'(first_val + i);
            if (release_last && i == n - 1) rmode = 0;
            @(negedge clk);
            check_output("wr_addr", ram_addr_a, addr_base + i);
            check_output("wr_en", ram_we_a, 1);
            @(posedge clk);
            #1;
            s_valid = 1'b0;
            if (i != n - 1) repeat (gap - 2) @(posedge clk);
        end
    endtask

    task automatic wait_drain();
        int cnt = 0;
        while ((sb.size() != 0 || m_valid) && cnt < 20000) begin
            @(negedge clk);
            cnt++;
        end
        check_output("drain_in_time", (cnt < 20000), 1);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #1500000;
        bad++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Directed sequence.
    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_m_valid", m_valid, 0);
        check_output("rst_m_last", m_last, 0);
        check_output("rst_m_data", m_data, 0);
        check_output("rst_overrun", overrun, 0);
        check_output("rst_win_count", win_count, 0);
        check_output("rst_addr_a", ram_addr_a, 0);
        check_output("rst_we_b", ram_we_b, 0);
        check_output("rst_data_b", ram_data_b, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // First two windows, fully drained.
        apply_stimulus(1, WIN, 4, 0, 1'b1, 1'b0);
        wait_drain();
        check_output("w1_win_count", win_count, 1);
        check_output("w1_overrun", overrun, 0);
        apply_stimulus(751, WIN, 4, 750, 1'b1, 1'b0);
        wait_drain();
        check_output("w2_win_count", win_count, 2);
        check_output("w2_overrun", overrun, 0);

        // Last handshake of one window coincides with completion of the next.
        rmode = 3;
        apply_stimulus(2001, WIN, 4, 0, 1'b1, 1'b0);
        @(negedge clk);
        check_output("w3_win_count", win_count, 3);
        apply_stimulus(3001, WIN, 4, 750, 1'b1, 1'b1);
        @(negedge clk);
        check_output("same_cycle_valid", m_valid, 0);
        check_output("same_cycle_addr_b", ram_addr_b, 750);
        check_output("same_cycle_overrun", overrun, 0);
        check_output("same_cycle_win_count", win_count, 4);
        repeat (2) @(negedge clk);
        check_output("same_cycle_latency_valid", m_valid, 1);
        check_output("same_cycle_first_data", m_data, 3001);
        wait_drain();

        // Random downstream ready.
        rmode = 2;
        apply_stimulus(4001, WIN, 8, 0, 1'b1, 1'b0);
        apply_stimulus(5001, WIN, 8, 750, 1'b1, 1'b0);
        wait_drain();
        rmode = 0;
        check_output("rand_win_count", win_count, 6);
        check_output("rand_overrun", overrun, 0);

        // Overrun: reader stalled while the following window completes.
        rmode = 1;
        apply_stimulus(6001, WIN, 4, 0, 1'b1, 1'b0);
        @(negedge clk);
        check_output("pre_ovr_win_count", win_count, 7);
        check_output("pre_ovr_overrun", overrun, 0);
        apply_stimulus(7001, WIN, 4, 750, 1'b0, 1'b0);
        @(negedge clk);
        check_output("ovr_overrun", overrun, 1);
        check_output("ovr_win_count", win_count, 7);
        check_output("ovr_stalled_valid", m_valid, 1);
        check_output("ovr_stalled_data", m_data, 6001);
        rmode = 0;
        apply_stimulus(8001, WIN, 4, 750, 1'b1, 1'b0);
        @(negedge clk);
        check_output("post_ovr_win_count", win_count, 8);

        // Reset mid-stream while a readout and a partial write are active.
        apply_stimulus(9001, 100, 4, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_output("mid_rst_m_valid", m_valid, 0);
        check_output("mid_rst_m_last", m_last, 0);
        check_output("mid_rst_win_count", win_count, 0);
        check_output("mid_rst_overrun", overrun, 0);
        check_output("mid_rst_addr_a", ram_addr_a, 0);

        // Normal operation resumes from half 0.
        apply_stimulus(10001, WIN, 4, 0, 1'b1, 1'b0);
        wait_drain();
        check_output("final_win_count", win_count, 1);
        check_output("final_overrun", overrun, 0);
        check_output("final_queue_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
